fifo_rd_stream_bridge: RTL
==========================

FIFO_RD_STREAM_BRIDGE -- requirements
Module: fifo_rd_stream_bridge

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width; must equal the upstream async FIFO WIDTH.
REQ-002 SHALL have port r_clk  input  1  read-domain clock; sole clock of the block.
REQ-003 SHALL have port r_rst  input  1  reset; one clock (r_clk), reset synchronous and active-high.
REQ-004 SHALL have port fifo_empty  input  1  async FIFO empty flag, read domain.
REQ-005 SHALL have port fifo_data  input  WIDTH  async FIFO data_out; valid the cycle after fifo_rd_en.
REQ-006 SHALL have port fifo_rd_en  output  1  async FIFO r_en; one word popped per asserted cycle.
REQ-007 SHALL have port m_valid  output  1  stream word available.
REQ-008 SHALL have port m_data  output  WIDTH  stream word.
REQ-009 SHALL have port m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-010 SHALL have port buf_cnt  output  2  occupancy of internal buffer, 0..3.
REQ-011 SHALL have port word_cnt  output  16  total words delivered downstream.

Function
REQ-012 SHALL contain a 3-entry FIFO-order buffer (head/tail pointers mod 3, count 0..3) and one inflight flag.
REQ-013 SHALL drive fifo_rd_en combinationally = !r_rst && !fifo_empty && (buf_cnt + inflight) < 3.
REQ-014 SHALL set inflight at the clock edge ending a cycle with fifo_rd_en=1, and clear it otherwise.
REQ-015 SHALL write fifo_data into the tail entry at the edge ending a cycle in which inflight=1.
REQ-016 SHALL drive m_valid = (buf_cnt != 0) and m_data = head entry, both from registered state.
REQ-017 SHALL remove the head entry at the edge ending a cycle with m_valid && m_ready.
REQ-018 SHALL handle push and pop in the same cycle: count unchanged, both pointers advance.
REQ-019 SHALL keep m_valid and m_data stable while m_valid && !m_ready.
REQ-020 SHALL never assert fifo_rd_en while fifo_empty=1; never overflow the buffer (count+inflight <= 3 invariant).
REQ-021 SHALL produce latency 2: fifo_rd_en in cycle N, data captured end of N+1, m_valid high in N+2.
REQ-022 SHALL sustain 1 word/cycle with m_ready held high and fifo_empty held low after the initial 2-cycle fill.
REQ-023 SHALL increment word_cnt by 1 per accepted transfer, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL deassert fifo_rd_en when buf_cnt=3, or buf_cnt=2 with inflight=1, regardless of m_ready in that cycle.
REQ-025 SHALL ignore fifo_data in any cycle with inflight=0.

Reset
REQ-026 SHALL, while r_rst=1 at a clock edge, clear buffer count, pointers, inflight and word_cnt to 0.
REQ-027 SHALL hold fifo_rd_en=0 during any cycle with r_rst=1.
REQ-028 SHALL present m_valid=0, buf_cnt=0, word_cnt=0 in the first cycle after reset.
REQ-029 SHALL, on reset mid-operation, discard buffered words and the word returned for an inflight read; no discarded word appears on m_data.
REQ-030 SHALL resume normal reads the first cycle r_rst=0 and fifo_empty=0.

Verification
REQ-031 SHALL cover: FIFO holds 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on three consecutive cycles starting 2 cycles after first fifo_rd_en; word_cnt=3.
REQ-032 SHALL cover: FIFO holds 5 words, m_ready=0 -> exactly 3 fifo_rd_en pulses, buf_cnt=3, m_data=first word stable; m_ready=1 -> all 5 delivered in order.
REQ-033 SHALL cover: m_ready toggling 1,0,1,0 with continuous FIFO data -> no word lost or duplicated, m_data stable on every m_ready=0 cycle.
REQ-034 SHALL cover: fifo_empty=1 throughout -> fifo_rd_en never asserted, m_valid=0.
REQ-035 SHALL cover: r_rst pulsed one cycle with buf_cnt=2 and inflight=1 -> next cycle buf_cnt=0, m_valid=0, word_cnt=0, inflight word never delivered.
REQ-036 SHALL cover: word_cnt preloaded via 65535 transfers, one more transfer -> word_cnt=0x0000.

Source files
------------

// File: rtl/fifo_rd_stream_bridge.sv
// Turns an async-FIFO read port (data one cycle after r_en) into a valid/ready stream; 2-cycle latency.
// Backpressure: a 3-entry skid buffer absorbs inflight reads, and reads stop once buffered + inflight reaches 3.
module fifo_rd_stream_bridge #(
    parameter int WIDTH = 8
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       buf_cnt,
    output logic [15:0]      word_cnt
);

    logic [WIDTH-1:0] mem [0:2];
    logic [1:0]       head;
    logic [1:0]       tail;
    logic             inflight;
    logic             push;
    logic             pop;
    logic [2:0]       occ;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Counting the inflight read as occupied guarantees its word always has a slot.
    assign occ        = {1'b0, buf_cnt} + {2'b00, inflight};
    assign fifo_rd_en = !r_rst && !fifo_empty && (occ < 3'd3);

    assign push    = inflight;
    assign pop     = m_valid && m_ready;
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = mem[head];

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
            word_cnt <= 16'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head     <= ptr_inc(head);
                word_cnt <= word_cnt + 16'd1;
            end
            if (push && !pop) begin
                buf_cnt <= buf_cnt + 2'd1;
            end else if (!push && pop) begin
                buf_cnt <= buf_cnt - 2'd1;
            end
        end
    end

    // Storage needs no reset: an entry is only visible after it has been written.
    always_ff @(posedge r_clk) begin
        if (!r_rst && push) begin
            mem[tail] <= fifo_data;
        end
    end

endmodule
